// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock-divider controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int MIN_RATIO = 2;
  localparam int MAX_W     = 16;

  function automatic logic [MAX_W-1:0] high_len(input logic [MAX_W-1:0] n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter plus registered div_clk/tick generation.
// Outputs reflect the counter value loaded on the same edge.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             run_next,
  input  logic [CNT_W-1:0] ratio,
  input  logic [CNT_W-1:0] ratio_next,
  output logic             div_clk,
  output logic             tick,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign wrap = run && (cnt == ratio - 1'b1);

  // Counter restarts at 0 on entry to run and after every boundary.
  always_comb begin
    cnt_nxt = '0;
    if (run_next && run && !wrap) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      div_clk <= run_next && (MAX_W'(cnt_nxt) < high_len(MAX_W'(ratio_next)));
      tick    <= run_next && (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: run/stop FSM, ratio handshake and pending ratio.
// Ratio updates while running take effect only at a period boundary.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DEF_RATIO = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_ratio,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_clk,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_ratio
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] ratio_q;
  logic [CNT_W-1:0] ratio_nxt;
  logic             pend_vld;
  logic             pend_vld_nxt;
  logic [CNT_W-1:0] pend_ratio;
  logic [CNT_W-1:0] pend_ratio_nxt;
  logic             wrap;
  logic             accept;
  logic             legal;

  assign cfg_ready = (state == IDLE) || !pend_vld;
  assign busy      = (state != IDLE);
  assign cur_ratio = ratio_q;
  assign accept    = cfg_valid && cfg_ready;
  assign legal     = (cfg_ratio >= CNT_W'(MIN_RATIO));

  always_comb begin
    state_nxt      = state;
    ratio_nxt      = ratio_q;
    pend_vld_nxt   = pend_vld;
    pend_ratio_nxt = pend_ratio;
    case (state)
      IDLE: begin
        // A ratio taken on the final boundary edge lands here; a fresh one wins.
        if (pend_vld) begin
          ratio_nxt    = pend_ratio;
          pend_vld_nxt = 1'b0;
        end
        if (accept && legal) begin
          ratio_nxt = cfg_ratio;
        end
        if (en) begin
          state_nxt = RUN;
        end
      end
      default: begin
        if (wrap) begin
          state_nxt = en ? RUN : IDLE;
          if (pend_vld) begin
            ratio_nxt    = pend_ratio;
            pend_vld_nxt = 1'b0;
          end
        end else begin
          state_nxt = en ? RUN : STOP;
        end
        if (accept && legal) begin
          pend_vld_nxt   = 1'b1;
          pend_ratio_nxt = cfg_ratio;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ratio_q    <= CNT_W'(DEF_RATIO);
      pend_vld   <= 1'b0;
      pend_ratio <= '0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      ratio_q    <= ratio_nxt;
      pend_vld   <= pend_vld_nxt;
      pend_ratio <= pend_ratio_nxt;
      cfg_err    <= accept && !legal;
    end
  end

  clk_div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .run       (state != IDLE),
    .run_next  (state_nxt != IDLE),
    .ratio     (ratio_q),
    .ratio_next(ratio_nxt),
    .div_clk   (div_clk),
    .tick      (tick),
    .wrap      (wrap)
  );

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Programmable clock-divider controller. It generates a divided clock `div_clk` and a one-cycle period-start `tick` from the system clock. It accepts divide-ratio updates through a valid/ready handshake and applies them only at period boundaries, so there are no runt pulses. Start and stop are always clean. It supersedes the fixed divide-by-2 block wherever a runtime-configurable ratio or a gated divided clock is needed.

Parameters:
- CNT_W, 8, width of ratio and internal period counter.
- DEF_RATIO, 2, active ratio after reset; must satisfy 2 <= DEF_RATIO <= 2^CNT_W-1.

Ports:
- clk        input   1      system clock, all logic on rising edge
- reset      input   1      asynchronous, active-low reset (0 = reset asserted)
- en         input   1      run request; level-sensitive
- cfg_valid  input   1      new ratio offered
- cfg_ratio  input   CNT_W  requested divide ratio N
- cfg_ready  output  1      controller can accept a ratio this cycle
- cfg_err    output  1      one-cycle pulse: accepted ratio was illegal (N<2) and was discarded
- div_clk    output  1      divided clock, registered
- tick       output  1      one-cycle pulse coincident with each div_clk rising edge
- busy       output  1      high in RUN or STOP
- cur_ratio  output  CNT_W  ratio currently in effect

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, active ratio=DEF_RATIO, pending empty. Outputs: div_clk=0, tick=0, cfg_ready=1, cfg_err=0, busy=0, cur_ratio=DEF_RATIO. Reset release is used synchronously; the first active edge after release may do work.
- Waveform for ratio N: cnt runs 0..N-1. Period boundary is the edge where cnt==N-1. div_clk=1 while cnt < N>>1, else 0. Odd N gives a longer low phase (N=3: 1 high, 2 low). N=2 gives an exact divide-by-2, 50% duty.
- tick=1 exactly in the cycle where cnt==0 while in RUN/STOP.
- States:
  - IDLE: div_clk=0, cnt held 0. If en=1, go to RUN; next cycle cnt=0, div_clk=1, tick=1. Latency from en sampled high to first div_clk high is 1 cycle.
  - RUN: counts. If en=0 is sampled before the boundary, go to STOP (waveform unchanged). At the boundary with en=1, wrap cnt to 0 and continue.
  - STOP: keeps counting the current period. If en returns to 1 before the boundary, go back to RUN with no gap. At the boundary with en still 0, go to IDLE with div_clk=0 and no extra tick.
- Config handshake: transfer happens when cfg_valid & cfg_ready on the same edge.
  - IDLE: cfg_ready=1. An accepted legal ratio becomes active on the next cycle (cur_ratio updates then).
  - RUN/STOP: cfg_ready = pending empty. An accepted ratio is stored as pending. At the next boundary, active ratio ← pending, pending is cleared, and cfg_ready rises the following cycle. The new period after that boundary uses the new N.
  - If the FSM enters IDLE with a pending ratio, the pending ratio is applied on that same boundary edge.
- Illegal ratio (0 or 1): accepted (handshake completes), cfg_err=1 for one cycle, active and pending ratios unchanged.
- Simultaneous events:
  - cfg transfer and boundary in the same cycle: the transfer is stored as pending and applies at the following boundary, not the current one.
  - en fall and cfg transfer together: both are honoured.
  - en rise in IDLE together with cfg transfer: the new ratio is loaded and RUN starts using it. The first period uses the new N.
- Reset mid-operation: immediately forces the reset values. The pending ratio is lost and div_clk drops asynchronously.

Decomposition:
- Package clk_div_pkg holds:
  - state enum {IDLE, RUN, STOP}
  - localparam MIN_RATIO=2
  - a function computing the high-phase length (N>>1)
- One natural sub-module: clk_div_core, containing the counter, high/low compare and tick. Inputs are the active ratio and run; outputs are div_clk, tick and wrap.
- The FSM, pending register and handshake stay in the top level.

Test Plan:
- Reset then en=1 with DEF_RATIO=2: div_clk toggles every cycle (1,0,1,0…); tick on every high cycle; busy=1; first high 1 cycle after en sampled.
- In IDLE, send cfg_ratio=5, then en=1: cur_ratio=5 next cycle; div_clk pattern 1,1,0,0,0 repeating; tick every 5 cycles.
- While running N=4, send N=3 mid-period: cfg_ready drops; pattern completes 1,1,0,0, then switches to 1,0,0; cfg_ready returns the cycle after the boundary; a second cfg offered while pending waits (not accepted).
- Send cfg_ratio=1 and then 0: cfg_err pulses once each, cur_ratio unchanged, waveform undisturbed.
- Running N=6, drop en at cnt=1: period completes (1,1,1,0,0,0), then IDLE with div_clk=0 and busy=0. Repeat, re-raising en at cnt=4: no gap, next tick on schedule.
- Assert reset=0 at cnt=2 of an N=6 period with a ratio pending: all outputs go to reset values immediately; after release, cur_ratio=DEF_RATIO.
